// File: rtl/iram_isp_loader_pkg.sv
// Shared constants and state encodings for the ISP boot loader.
// Error codes, AXI response code and both FSM encodings live here.
package iram_isp_loader_pkg;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OVF   = 2'b01;
  localparam logic [1:0] ERR_LEN   = 2'b10;
  localparam logic [1:0] ERR_BRESP = 2'b11;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    M_IDLE  = 3'd0,
    M_LEN   = 3'd1,
    M_DATA  = 3'd2,
    M_DRAIN = 3'd3,
    M_DONE  = 3'd4,
    M_ERR   = 3'd5
  } main_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  // Byte strobe for a word whose highest filled byte lane is last_pos.
  function automatic logic [3:0] strb_for(input logic [1:0] last_pos);
    logic [3:0] s;
    case (last_pos)
      2'd0:    s = 4'b0001;
      2'd1:    s = 4'b0011;
      2'd2:    s = 4'b0111;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/iram_ldr_fifo.sv
// Small synchronous FIFO holding packed {word, strb} entries for the loader.
// Flush empties it in one cycle; a push when full is dropped unless a pop frees a slot.
module iram_ldr_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/iram_isp_loader.sv
// ISP boot loader: length-prefixed byte stream in, little-endian 32-bit
// AXI4-Lite writes out to the instruction RAM, one outstanding write at a time.
module iram_isp_loader
  import iram_isp_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned IRAM_BYTES = 32768,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        rx_vld_i,
  input  logic [7:0]  rx_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  err_o,
  output logic [31:0] axi_awaddr,
  output logic [2:0]  axi_awprot,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic [1:0]  axi_bresp,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  output logic [2:0]  dbg_main_state,
  output logic [1:0]  dbg_wr_state
);

  main_state_t state, state_nxt;
  wr_state_t   wstate, wstate_nxt;
  logic [1:0]  err_q, err_nxt;

  logic [1:0]  lcnt;
  logic [31:0] len_q, len_full, rem_q;
  logic [1:0]  bpos;
  logic [31:0] word_q, word_nxt;
  logic        pend_vld, pend_last;
  logic [31:0] pend_word;
  logic [3:0]  pend_strb;
  logic [29:0] word_idx;

  logic        fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [35:0] fifo_dout;
  logic        start, rx_len, rx_dat, ovf, bresp_err, aw_hs;

  assign start    = en_i && (state inside {M_IDLE, M_DONE, M_ERR});
  assign rx_len   = rx_vld_i && (state == M_LEN);
  assign rx_dat   = rx_vld_i && (state == M_DATA) && (rem_q != 32'd0);
  assign len_full = {rx_data_i, len_q[31:8]};

  // Handshake: AW and W are offered together and held stable; a beat is taken
  // only in a cycle where awready and wready are both high. B is taken on bvalid.
  assign aw_hs      = (wstate == W_REQ) && axi_awready && axi_wready;
  assign bresp_err  = (wstate == W_RESP) && axi_bvalid && (axi_bresp != AXI_RESP_OKAY);
  assign fifo_push  = pend_vld && (state == M_DATA);
  assign fifo_pop   = aw_hs;
  assign fifo_flush = bresp_err;
  assign ovf        = fifo_push && fifo_full && !fifo_pop;

  always_comb begin
    word_nxt = (bpos == 2'd0) ? 32'h0 : word_q;
    word_nxt[{bpos, 3'b000} +: 8] = rx_data_i;
  end

  iram_ldr_fifo #(
    .DEPTH(BUF_DEPTH),
    .W    (36)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(fifo_flush),
    .push (fifo_push),
    .din  ({pend_word, pend_strb}),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    case (state)
      M_IDLE, M_DONE, M_ERR: begin
        if (en_i) begin
          state_nxt = M_LEN;
          err_nxt   = ERR_NONE;
        end
      end
      M_LEN: begin
        if (rx_len && lcnt == 2'd3) begin
          if (len_full == 32'd0) begin
            state_nxt = M_DONE;
          end else if (len_full > IRAM_BYTES) begin
            state_nxt = M_ERR;
            err_nxt   = ERR_LEN;
          end else begin
            state_nxt = M_DATA;
          end
        end
      end
      M_DATA: begin
        if (ovf) begin
          state_nxt = M_ERR;
          err_nxt   = ERR_OVF;
        end else if (fifo_push && pend_last) begin
          state_nxt = M_DRAIN;
        end
      end
      M_DRAIN: begin
        // The cycle of the final B handshake already counts as drained.
        if (fifo_empty && (wstate == W_IDLE || (wstate == W_RESP && axi_bvalid)))
          state_nxt = M_DONE;
      end
      default: state_nxt = M_IDLE;
    endcase
    if (bresp_err && busy_o) begin
      state_nxt = M_ERR;
      err_nxt   = ERR_BRESP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= M_IDLE;
      err_q <= ERR_NONE;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt      <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      bpos      <= '0;
      word_q    <= '0;
      pend_vld  <= 1'b0;
      pend_last <= 1'b0;
      pend_word <= '0;
      pend_strb <= '0;
    end else begin
      pend_vld <= 1'b0;
      if (start) begin
        lcnt  <= '0;
        len_q <= '0;
        rem_q <= '0;
        bpos  <= '0;
      end
      if (rx_len) begin
        len_q <= len_full;
        lcnt  <= lcnt + 2'd1;
        if (lcnt == 2'd3) begin
          rem_q <= len_full;
          bpos  <= '0;
        end
      end
      if (rx_dat) begin
        word_q <= word_nxt;
        bpos   <= bpos + 2'd1;
        rem_q  <= rem_q - 32'd1;
        if (bpos == 2'd3 || rem_q == 32'd1) begin
          pend_vld  <= 1'b1;
          pend_word <= word_nxt;
          pend_strb <= strb_for(bpos);
          pend_last <= (rem_q == 32'd1);
        end
      end
    end
  end

  // Head entry stays in the FIFO until AW/W is accepted, so the output
  // registers never hold a word the buffer has already given up.
  always_comb begin
    wstate_nxt = wstate;
    case (wstate)
      W_IDLE:  if (!fifo_empty) wstate_nxt = W_REQ;
      W_REQ:   if (aw_hs)       wstate_nxt = W_RESP;
      W_RESP:  if (axi_bvalid)  wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate     <= W_IDLE;
      axi_awaddr <= '0;
      axi_wdata  <= '0;
      axi_wstrb  <= '0;
      word_idx   <= '0;
    end else begin
      wstate <= wstate_nxt;
      if (wstate == W_IDLE && !fifo_empty) begin
        axi_awaddr <= BASE_ADDR + {word_idx, 2'b00};
        axi_wdata  <= fifo_dout[35:4];
        axi_wstrb  <= fifo_dout[3:0];
      end
      if (wstate == W_RESP && axi_bvalid) word_idx <= word_idx + 30'd1;
      if (start) word_idx <= '0;
    end
  end

  assign axi_awprot     = 3'b000;
  assign axi_awvalid    = (wstate == W_REQ);
  assign axi_wvalid     = (wstate == W_REQ);
  assign axi_bready     = (wstate == W_RESP);
  assign busy_o         = state inside {M_LEN, M_DATA, M_DRAIN};
  assign done_o         = (state == M_DONE);
  assign err_o          = err_q;
  assign dbg_main_state = state;
  assign dbg_wr_state   = wstate;

endmodule

// File: tb/tb_iram_isp_loader.sv
// Bench for iram_isp_loader: directed loads from the test plan plus random
// loads checked against a byte-level model of the expected AXI writes.
module tb_iram_isp_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_i = 1'b0;
  logic        rx_vld_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        busy_o, done_o;
  logic [1:0]  err_o;
  logic [31:0] axi_awaddr, axi_wdata;
  logic [2:0]  axi_awprot;
  logic        axi_awvalid, axi_wvalid, axi_bready;
  logic [3:0]  axi_wstrb;
  logic        axi_awready = 1'b0, axi_wready = 1'b0, axi_bvalid = 1'b0;
  logic [1:0]  axi_bresp = 2'b00;
  logic [2:0]  dbg_main_state;
  logic [1:0]  dbg_wr_state;

  always #5 clk = ~clk;

  iram_isp_loader dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .rx_vld_i(rx_vld_i), .rx_data_i(rx_data_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .dbg_main_state(dbg_main_state), .dbg_wr_state(dbg_wr_state)
  );

  // Scoreboard entries are {addr, data, strb}.
  logic [67:0] exp_q[$];
  logic [67:0] act_q[$];
  logic [7:0]  pay_q[$];
  logic [7:0]  tx_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_b_cyc = 0;
  int done_rise_cyc = 0;
  int aw_seen = 0;
  bit done_prev = 1'b0;
  bit resp_pend = 1'b0;
  bit b_done = 1'b0;
  bit ready_en = 1'b1;
  bit rand_ready = 1'b0;
  logic [1:0] bresp_val = 2'b00;

  // Monitor: samples settled outputs on the active edge.
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (axi_awvalid && axi_awready && axi_wvalid && axi_wready) begin
        act_q.push_back({axi_awaddr, axi_wdata, axi_wstrb});
        resp_pend = 1'b1;
      end
      if (axi_bvalid && axi_bready) begin
        b_done = 1'b1;
        last_b_cyc = cyc;
      end
      if (axi_awvalid) aw_seen++;
      if (done_o && !done_prev) done_rise_cyc = cyc;
      done_prev = done_o;
    end
  end

  // Slave: drives ready/response on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      axi_bvalid = 1'b0;
      resp_pend = 1'b0;
      b_done = 1'b0;
      axi_awready = 1'b0;
      axi_wready = 1'b0;
    end else begin
      if (b_done) begin
        axi_bvalid = 1'b0;
        b_done = 1'b0;
      end
      if (resp_pend) begin
        axi_bvalid = 1'b1;
        axi_bresp = bresp_val;
        resp_pend = 1'b0;
      end
      if (!ready_en) begin
        axi_awready = 1'b0;
        axi_wready = 1'b0;
      end else if (rand_ready && (cyc % 4 != 3)) begin
        axi_awready = 1'($urandom_range(0, 1));
        axi_wready = 1'($urandom_range(0, 1));
      end else begin
        axi_awready = 1'b1;
        axi_wready = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_load();
    @(negedge clk);
    en_i = 1'b1;
    @(negedge clk);
    en_i = 1'b0;
  endtask

  task automatic send(input int gap_min, input int gap_max);
    while (tx_q.size() > 0) begin
      @(negedge clk);
      rx_vld_i = 1'b1;
      rx_data_i = tx_q.pop_front();
      repeat ($urandom_range(gap_min, gap_max)) begin
        @(negedge clk);
        rx_vld_i = 1'b0;
      end
    end
    @(negedge clk);
    rx_vld_i = 1'b0;
  endtask

  // Reference model: length prefix LSB first, then payload bytes packed
  // four per word at consecutive word addresses, partial last word zero-filled.
  task automatic make_load(input int len);
    logic [31:0] lv;
    logic [31:0] data;
    logic [3:0]  strb;
    lv = len;
    tx_q.delete();
    exp_q.delete();
    for (int k = 0; k < 4; k++) tx_q.push_back(lv[8*k +: 8]);
    for (int i = 0; i < len; i++) tx_q.push_back(pay_q[i]);
    for (int w = 0; w * 4 < len; w++) begin
      data = 32'h0;
      strb = 4'h0;
      for (int k = 0; k < 4; k++) begin
        if (w * 4 + k < len) begin
          data[8*k +: 8] = pay_q[w*4 + k];
          strb[k] = 1'b1;
        end
      end
      exp_q.push_back({32'(4 * w), data, strb});
    end
  endtask

  task automatic rand_payload(input int len);
    pay_q.delete();
    for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
  endtask

  task automatic wait_end(input int budget, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (done_o || err_o != 2'b00) hit = 1'b1;
    end
    chk(tag, 68'(hit), 68'd1);
  endtask

  task automatic check_done(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_done"}, 68'(done_o), 68'd1);
    chk({tag, "_err"}, 68'(err_o), 68'd0);
    chk({tag, "_nwr"}, 68'(act_q.size()), 68'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), act_q[i], exp_q[i]);
    chk({tag, "_done_lat"}, 68'(done_rise_cyc), 68'(last_b_cyc + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctl", 68'({busy_o, done_o, err_o, axi_awvalid, axi_wvalid, axi_bready}), 68'd0);
    chk("rst_axi", 68'({axi_awaddr, axi_wdata, axi_wstrb, axi_awprot}), 68'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ctl", 68'({busy_o, done_o, err_o}), 68'd0);

    // Directed 8-byte load against a zero-wait slave.
    pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    make_load(8);
    act_q.delete();
    start_load();
    chk("t1_busy", 68'(busy_o), 68'd1);
    send(0, 0);
    wait_end(200, "t1_end");
    check_done("t1");
    chk("t1_w0", act_q[0], {32'h0, 32'h44332211, 4'hF});
    chk("t1_w1", act_q[1], {32'h4, 32'h88776655, 4'hF});
    tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    send(0, 0);
    repeat (5) @(negedge clk);
    chk("t1_ignore_n", 68'(act_q.size()), 68'd2);
    chk("t1_ignore_done", 68'(done_o), 68'd1);

    // Partial final word.
    pay_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    make_load(5);
    act_q.delete();
    start_load();
    send(0, 0);
    wait_end(200, "t2_end");
    check_done("t2");
    chk("t2_w1", act_q[1], {32'h4, 32'h000000EE, 4'h1});

    // Zero length: done the cycle after the 4th length byte, no AW ever.
    pay_q.delete();
    make_load(0);
    act_q.delete();
    start_load();
    aw_seen = 0;
    send(0, 0);
    chk("t3_done", 68'(done_o), 68'd1);
    repeat (10) @(negedge clk);
    chk("t3_aw", 68'(aw_seen), 68'd0);
    chk("t3_nwr", 68'(act_q.size()), 68'd0);

    // Oversized length.
    act_q.delete();
    start_load();
    tx_q = '{8'h04, 8'h80, 8'h00, 8'h00};
    send(0, 0);
    chk("t4_err", 68'(err_o), 68'd2);
    chk("t4_busy", 68'({busy_o, done_o}), 68'd0);
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send(0, 0);
    repeat (5) @(negedge clk);
    chk("t4_nwr", 68'(act_q.size()), 68'd0);
    chk("t4_err_hold", 68'(err_o), 68'd2);
    start_load();
    chk("t4_restart_busy", 68'(busy_o), 68'd1);
    chk("t4_restart_err", 68'(err_o), 68'd0);
    pay_q.delete();
    make_load(0);
    send(0, 0);
    chk("t4_zero_done", 68'(done_o), 68'd1);

    // Overflow with the slave stalled.
    ready_en = 1'b0;
    rand_payload(12);
    make_load(12);
    act_q.delete();
    start_load();
    send(0, 0);
    repeat (3) @(negedge clk);
    chk("t5_err", 68'(err_o), 68'd1);
    chk("t5_nwr_stalled", 68'(act_q.size()), 68'd0);
    ready_en = 1'b1;
    repeat (40) @(negedge clk);
    chk("t5_nwr", 68'(act_q.size()), 68'd2);
    for (int i = 0; i < 2 && i < act_q.size(); i++)
      chk($sformatf("t5_wr%0d", i), act_q[i], exp_q[i]);
    chk("t5_busy", 68'(busy_o), 68'd0);

    // Error response on the first write.
    bresp_val = 2'b10;
    rand_payload(12);
    make_load(12);
    act_q.delete();
    start_load();
    send(0, 0);
    repeat (20) @(negedge clk);
    chk("t6_err", 68'(err_o), 68'd3);
    chk("t6_nwr", 68'(act_q.size()), 68'd1);
    chk("t6_wr0", act_q[0], exp_q[0]);
    bresp_val = 2'b00;

    // Reset in the middle of the payload, then a clean load.
    rand_payload(16);
    make_load(16);
    start_load();
    repeat (6) void'(tx_q.pop_back());
    send(0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_ctl", 68'({busy_o, done_o, err_o, axi_awvalid, axi_wvalid, axi_bready}), 68'd0);
    chk("t7_rst_axi", 68'({axi_awaddr, axi_wdata, axi_wstrb}), 68'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_payload(11);
    make_load(11);
    act_q.delete();
    start_load();
    send(0, 0);
    wait_end(300, "t7_end");
    check_done("t7");

    // Random loads, alternating zero-wait and randomly stalling slave.
    for (int t = 0; t < 6; t++) begin
      int len;
      len = $urandom_range(1, 40);
      rand_ready = t[0];
      rand_payload(len);
      make_load(len);
      act_q.delete();
      start_load();
      if (rand_ready) send(1, 3);
      else send(0, 1);
      wait_end(2000, $sformatf("r%0d_end", t));
      check_done($sformatf("r%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iram_isp_loader.md
Name: iram_isp_loader

Overview:
- ISP-region boot loader engine: receives a length-prefixed byte stream (UART RX side), packs bytes little-endian into 32-bit words and writes them sequentially into the instruction RAM through the iram AXI4-Lite slave write channels.
- Sits between the UART receiver and the iram AXI slave port, either directly or via the bus fabric. Raises done_o so ISP firmware or the core can release execution to 0x0000_0000.
- Write-only master: AR/R channels are not implemented.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- IRAM_BYTES, 32768, capacity; larger lengths are rejected.
- BUF_DEPTH, 2, packed-word buffer depth (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en_i  in  1  single-cycle start pulse; honoured only in IDLE, DONE or ERR
- rx_vld_i  in  1  byte valid, one cycle per byte, no backpressure
- rx_data_i  in  8  received byte
- busy_o  out  1  high in LEN, DATA and DRAIN
- done_o  out  1  load completed without error (level)
- err_o  out  2  00 none, 01 buffer overflow, 10 length > IRAM_BYTES, 11 bresp ≠ OKAY
- axi_awaddr  out  32  write address
- axi_awprot  out  3  constant 0
- axi_awvalid  out  1  write address valid
- axi_awready  in  1  write address ready
- axi_wdata  out  32  write data
- axi_wstrb  out  4  byte strobes
- axi_wvalid  out  1  write data valid
- axi_wready  in  1  write data ready
- axi_bresp  in  2  write response
- axi_bvalid  in  1  write response valid
- axi_bready  out  1  write response ready

Behaviour:
- Reset: all outputs 0, both FSMs idle, buffer empty, counters 0. Reset asserted mid-load abandons the load immediately; a partial write already accepted by the slave is not undone.
- Main FSM states:
  - IDLE --en_i--> LEN.
  - LEN: collect 4 bytes into len[31:0], LSB first.
    - After byte 4: if len == 0 → DONE.
    - Else if len > IRAM_BYTES → ERR(10).
    - Else → DATA.
  - DATA: assemble bytes into a word shift register (byte k lands in bits 8k+7:8k). Push {word, strb} to the buffer on the 4th byte or on the last payload byte.
    - Partial final word: strb = 0001, 0011 or 0111 for 1, 2 or 3 remaining bytes.
    - Unused data bits are 0.
    - After the last byte is pushed → DRAIN.
  - DRAIN: wait until the buffer is empty and the write FSM is idle → DONE.
  - DONE: done_o = 1. en_i clears done_o and → LEN.
  - ERR: err_o holds its code, busy_o = 0, all further rx bytes ignored. en_i clears err_o and → LEN.
  - en_i while busy is ignored. rx bytes in IDLE, DONE or ERR are ignored.
- Overflow: a push while the buffer is full → ERR(01). The byte is dropped and already-queued words still drain.
- Write FSM states:
  - WIDLE: if the buffer is non-empty, pop into the output registers next cycle → WREQ.
  - WREQ: axi_awvalid = axi_wvalid = 1 with stable addr/data/strb.
    - The slave asserts awready and wready together; the handshake completes when both are seen high in the same cycle.
    - If awready and wready differ within a cycle, neither is treated as accepted and both valids stay asserted.
    - On handshake → WRESP.
  - WRESP: axi_bready = 1; on bvalid → WIDLE and the address advances by 4. bresp ≠ 00 → ERR(11) and the buffer is flushed.
- Address: axi_awaddr = BASE_ADDR + 4*word_index, with a 30-bit word counter. Wrap-around is impossible because length is bounded.
- Latency:
  - Last rx byte to push: 1 cycle.
  - Push to awvalid: 2 cycles (WIDLE then WREQ).
  - Minimum 3 cycles per word against a zero-wait slave.
  - done_o rises 1 cycle after the final bvalid handshake.
- Simultaneous push and pop in one cycle is legal, and the buffer count is unchanged.

Decomposition:
- Shared package/defines: error code constants (ERR_NONE, ERR_OVF, ERR_LEN, ERR_BRESP), main and write FSM state encodings, AXI_RESP_OKAY.
- Sub-module: iram_ldr_fifo, a synchronous BUF_DEPTH × 36-bit FIFO (data + strb) with full/empty flags and a flush input.
- Top level holds byte packing, length capture, both FSMs and the AXI output registers.

Test Plan:
- Start, then bytes 08 00 00 00 11 22 33 44 55 66 77 88, zero-wait slave → writes (0x0, 0x44332211, F) and (0x4, 0x88776655, F), done_o = 1, err_o = 00.
- Length 5, payload AA BB CC DD EE → second write (0x4, 0x000000EE, strb 0001), then done.
- Length 0 → done_o one cycle after the 4th length byte, no awvalid ever asserted.
- Length 0x00008004 with IRAM_BYTES = 32768 → err_o = 10, no AXI writes, following bytes ignored; en_i → busy_o = 1, err_o = 00.
- awready/wready held low while 12 payload bytes stream at 1 byte/cycle → the third packed word overflows BUF_DEPTH = 2, err_o = 01, exactly 2 words written after ready is released.
- bresp = 10 on the first write → err_o = 11, no further writes. rst_n pulse mid-DATA → all outputs 0, and a fresh en_i load completes normally.
